// File: rtl/sync_down_counter.sv
// Loadable N-bit down counter with one-shot / auto-reload modes and a registered terminal-count pulse.
// Optional cascade output borrow_out is enabled by defining DOWN_CNT_BORROW_OUT_EN.
module sync_down_counter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         mode,
  output logic [N-1:0] qout,
  output logic         tc,
  output logic         busy,
  output logic         done
`ifdef DOWN_CNT_BORROW_OUT_EN
  ,
  output logic         borrow_out
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] reload_q, reload_d;
  logic         mode_q, mode_d;
  logic         tc_q, tc_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state and count logic; load outranks counting
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;

    if (load) begin
      cnt_d    = load_value;
      reload_d = load_value;
      mode_d   = mode;
      if (load_value != '0) begin
        state_d = RUN;
      end else begin
        // A zero period is never run: flag it and park
        tc_d    = 1'b1;
        state_d = mode ? IDLE : DONE;
      end
    end else if (state_q == RUN && enable) begin
      if (cnt_q > N'(1)) begin
        cnt_d = cnt_q - N'(1);
      end else if (cnt_q == N'(1)) begin
        cnt_d   = '0;
        tc_d    = 1'b1;
        state_d = mode_q ? RUN : DONE;
      end else begin
        cnt_d = reload_q;
      end
    end
  end

  assign qout = cnt_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

`ifdef DOWN_CNT_BORROW_OUT_EN
  // Fires the cycle before tc so a following stage can use it as its enable
  assign borrow_out = busy & enable & ~load & (cnt_q == N'(1));
`endif

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter: per-cycle reference model plus directed literal checks.
module tb_sync_down_counter;

  localparam int unsigned N = 4;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         load;
  logic [N-1:0] load_value;
  logic         mode;
  logic [N-1:0] qout;
  logic         tc;
  logic         busy;
  logic         done;
`ifdef DOWN_CNT_BORROW_OUT_EN
  logic         borrow_out;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Reference model: 0 = idle, 1 = running, 2 = finished
  int m_q, m_rel, m_mode, m_tc, m_state;

  sync_down_counter #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .mode       (mode),
    .qout       (qout),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
`ifdef DOWN_CNT_BORROW_OUT_EN
    ,
    .borrow_out (borrow_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model advances on each rising edge from the inputs held stable around it
  always @(posedge clk) begin
    int p;
    int nq;
    if (reset) begin
      m_q = 0; m_rel = 0; m_mode = 0; m_tc = 0; m_state = 0;
    end else if (load) begin
      m_q = int'(load_value); m_rel = int'(load_value); m_mode = int'(mode);
      if (load_value == 0) begin
        m_tc = 1;
        m_state = mode ? 0 : 2;
      end else begin
        m_tc = 0;
        m_state = 1;
      end
    end else begin
      m_tc = 0;
      if (m_state == 1 && enable) begin
        if (m_mode == 1) begin
          p  = m_rel + 1;
          nq = (m_q + p - 1) % p;
          m_tc = (m_q != 0 && nq == 0) ? 1 : 0;
          m_q  = nq;
        end else begin
          m_q  = m_q - 1;
          m_tc = (m_q == 0) ? 1 : 0;
          if (m_q == 0) m_state = 2;
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_qout", int'(qout), m_q);
      chk("model_tc",   int'(tc),   m_tc);
      chk("model_busy", int'(busy), (m_state == 1) ? 1 : 0);
      chk("model_done", int'(done), (m_state == 2) ? 1 : 0);
`ifdef DOWN_CNT_BORROW_OUT_EN
      chk("model_borrow", int'(borrow_out),
          (m_state == 1 && enable && !load && m_q == 1) ? 1 : 0);
`endif
    end
  end

  // Apply inputs for one edge, return 2 time units after it
  task automatic cyc(input bit r, input bit en, input bit ld, input int lv, input bit md);
    reset = r; enable = en; load = ld; load_value = N'(lv); mode = md;
    @(posedge clk);
    #2;
  endtask

  int seq_a[8] = '{2, 1, 0, 3, 2, 1, 0, 3};
  int tc_a[8]  = '{0, 0, 1, 0, 0, 0, 1, 0};
  int en_g[6]  = '{1, 0, 0, 1, 1, 1};
  int q_g[6]   = '{3, 3, 3, 2, 1, 0};

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; load_value = '0; mode = 1'b0;
    @(posedge clk); #2;

    // Reset beats a concurrent load
    cyc(1, 0, 1, 9, 0);
    cyc(1, 0, 1, 9, 0);
    chk_on = 1'b1;
    chk("rst_qout", int'(qout), 0);
    chk("rst_tc",   int'(tc),   0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // One-shot from 5
    cyc(0, 0, 1, 5, 0);
    chk("os_load_q", int'(qout), 5);
    chk("os_load_busy", int'(busy), 1);
    for (int i = 4; i >= 0; i--) begin
      cyc(0, 1, 0, 0, 0);
      chk("os_q", int'(qout), i);
      chk("os_tc", int'(tc), (i == 0) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    chk("os_hold_q", int'(qout), 0);
    chk("os_hold_done", int'(done), 1);
    chk("os_hold_tc", int'(tc), 0);

    // Auto-reload with period 4
    cyc(0, 0, 1, 3, 1);
    chk("ar_load_q", int'(qout), 3);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, 0);
      chk("ar_q", int'(qout), seq_a[i]);
      chk("ar_tc", int'(tc), tc_a[i]);
      chk("ar_busy", int'(busy), 1);
    end

    // Enable gating
    cyc(0, 0, 1, 4, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, en_g[i] != 0, 0, 0, 0);
      chk("gate_q", int'(qout), q_g[i]);
      chk("gate_tc", int'(tc), (i == 5) ? 1 : 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("gate_tc_clear", int'(tc), 0);

    // Load priority over enable, then zero load
    cyc(0, 0, 1, 7, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    chk("lp_at2", int'(qout), 2);
    cyc(0, 1, 1, 15, 0);
    chk("lp_q15", int'(qout), 15);
    cyc(0, 1, 1, 0, 0);
    chk("z_q", int'(qout), 0);
    chk("z_tc", int'(tc), 1);
    chk("z_done", int'(done), 1);
    cyc(0, 1, 0, 0, 0);
    chk("z_tc_once", int'(tc), 0);
    cyc(0, 1, 1, 0, 1);
    chk("z_auto_tc", int'(tc), 1);
    chk("z_auto_idle", int'(busy) + int'(done), 0);
    cyc(0, 1, 0, 0, 0);
    chk("z_auto_stay_idle", int'(busy), 0);

    // Full-range auto-reload wraps back to 15 after 16 enabled cycles
    cyc(0, 0, 1, 15, 1);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 0);
    chk("max_wrap_q", int'(qout), 15);

    // Reset mid-run in auto mode
    cyc(0, 0, 1, 9, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("mr_at7", int'(qout), 7);
    cyc(1, 1, 1, 12, 1);
    chk("mr_q", int'(qout), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_tc", int'(tc), 0);
    cyc(0, 1, 0, 0, 0);
    chk("mr_idle_q", int'(qout), 0);

    // Reset clears a pending tc
    cyc(0, 0, 1, 1, 0);
    cyc(1, 1, 0, 0, 0);
    chk("mr_tc_cleared", int'(tc), 0);
    cyc(0, 0, 0, 0, 0);

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
